// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between fetch and load/store, routing in-order responses by owner tag
module mem_bus_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        err_spurious
);
    localparam int PW = $clog2(DEPTH);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t           state;
    logic             gnt_data;
    logic [DEPTH-1:0] tags;
    logic [PW-1:0]    head, tail;
    logic [PW:0]      count;
    logic             full, sel_data, live, hs, pop, head_tag;
    assign full     = count == (PW+1)'(DEPTH);
    // in HOLD the registered grant wins even if data_req rises meanwhile
    assign sel_data = state == HOLD ? gnt_data : data_req;
    assign live     = sel_data ? data_req : inst_req;
    assign req      = reset & live & ~full;
    assign hs       = req & addr_ok;
    assign pop      = data_ok & (count != '0);
    assign head_tag = tags[head];
    assign wr       = req & sel_data & data_wr;
    assign size     = ~req ? 2'b00 : sel_data ? data_size : 2'b10;
    assign wstrb    = req & sel_data ? data_wstrb : 4'b0000;
    assign addr     = ~req ? '0 : sel_data ? data_addr : inst_addr;
    assign wdata    = req & sel_data ? data_wdata : '0;
    assign inst_addr_ok = hs & ~sel_data;
    assign data_addr_ok = hs & sel_data;
    assign inst_data_ok = pop & ~head_tag;
    assign data_data_ok = pop & head_tag;
    assign inst_rdata   = inst_data_ok ? rdata : '0;
    assign data_rdata   = data_data_ok ? rdata : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gnt_data     <= 1'b0;
            tags         <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            err_spurious <= 1'b0;
        end else begin
            state    <= req & ~addr_ok ? HOLD : IDLE;
            gnt_data <= sel_data;
            if (hs) begin
                tags[tail] <= sel_data;
                tail       <= tail + 1'b1;
            end
            if (pop)
                head <= head + 1'b1;
            count        <= count + (PW+1)'(hs) - (PW+1)'(pop);
            err_spurious <= err_spurious | (data_ok & (count == '0));
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scenarios plus random traffic against a queue-based reference model
module tb_mem_bus_arbiter;
    localparam int DEPTH = 2;
    logic        clk = 1'b0, reset = 1'b0;
    logic        inst_req = 0, data_req = 0, data_wr = 0, addr_ok = 0, data_ok = 0;
    logic [31:0] inst_addr = 0, data_addr = 0, data_wdata = 0, rdata = 0;
    logic [1:0]  data_size = 0;
    logic [3:0]  data_wstrb = 0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        req, wr, err_spurious;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] inst_rdata, data_rdata, addr, wdata;
    int checks = 0, errors = 0;
    int q[$];
    int held = -1;
    bit err_m = 0;

    mem_bus_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .wstrb(wstrb), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // compares every output with the model, then advances model and clock
    task automatic step();
        int win;
        bit live, rq, dsel, acc, pop;
        if (!reset) begin
            q.delete();
            held = -1;
            err_m = 0;
        end
        win  = held >= 0 ? held : data_req ? 1 : inst_req ? 0 : -1;
        live = win == 1 ? data_req : win == 0 ? inst_req : 1'b0;
        rq   = reset && live && q.size() < DEPTH;
        dsel = win == 1;
        acc  = rq && addr_ok;
        pop  = reset && data_ok && q.size() > 0;
        chk("req", req, rq);
        chk("addr", addr, !rq ? 32'h0 : dsel ? data_addr : inst_addr);
        chk("wr", wr, rq && dsel && data_wr);
        chk("size", size, !rq ? 32'h0 : dsel ? data_size : 32'h2);
        chk("wstrb", wstrb, rq && dsel ? data_wstrb : 4'h0);
        chk("wdata", wdata, rq && dsel ? data_wdata : 32'h0);
        chk("inst_addr_ok", inst_addr_ok, acc && !dsel);
        chk("data_addr_ok", data_addr_ok, acc && dsel);
        chk("inst_data_ok", inst_data_ok, pop && q[0] == 0);
        chk("data_data_ok", data_data_ok, pop && q[0] == 1);
        chk("inst_rdata", inst_rdata, (pop && q[0] == 0) ? rdata : 32'h0);
        chk("data_rdata", data_rdata, (pop && q[0] == 1) ? rdata : 32'h0);
        chk("err_spurious", err_spurious, err_m);
        if (reset) begin
            if (data_ok && q.size() == 0) err_m = 1;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(win);
            held = (rq && !addr_ok) ? win : -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        #4;
        step();
    endtask

    task automatic idle_inputs();
        inst_req = 0; data_req = 0; addr_ok = 0; data_ok = 0; data_wr = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        inst_req = 1; data_req = 1; addr_ok = 1; data_ok = 1;
        #4;
        chk("rst_req", req, 0);
        step();
        idle_inputs();
        reset = 1;
        tick();
        // single load
        data_req = 1; data_addr = 32'h1000; data_size = 2; addr_ok = 1;
        #4;
        chk("t1_req", req, 1);
        chk("t1_addr", addr, 32'h1000);
        chk("t1_addr_ok", data_addr_ok, 1);
        step();
        idle_inputs();
        tick();
        data_ok = 1; rdata = 32'hDEADBEEF;
        #4;
        chk("t1_data_ok", data_data_ok, 1);
        chk("t1_rdata", data_rdata, 32'hDEADBEEF);
        chk("t1_inst_ok", inst_data_ok, 0);
        step();
        idle_inputs();
        // hold keeps fetch grant even when data_req rises
        inst_req = 1; inst_addr = 32'h2000;
        tick();
        tick();
        data_req = 1; data_addr = 32'h3000; data_wr = 1; data_wstrb = 4'b0011;
        #4;
        chk("hold_addr", addr, 32'h2000);
        step();
        addr_ok = 1;
        #4;
        chk("hold_inst_ok", inst_addr_ok, 1);
        chk("hold_data_ok0", data_addr_ok, 0);
        step();
        inst_req = 0;
        #4;
        chk("next_data_grant", data_addr_ok, 1);
        chk("store_wstrb", wstrb, 4'b0011);
        step();
        idle_inputs();
        data_ok = 1; rdata = 32'h11112222;
        #4;
        chk("order_first_inst", inst_data_ok, 1);
        step();
        #4;
        chk("order_second_data", data_data_ok, 1);
        step();
        idle_inputs();
        // both from idle: data wins
        inst_req = 1; data_req = 1; addr_ok = 1;
        #4;
        chk("prio_data", data_addr_ok, 1);
        chk("prio_inst", inst_addr_ok, 0);
        step();
        idle_inputs();
        data_ok = 1;
        tick();
        idle_inputs();
        // full blocks req, reopens the cycle after a pop
        inst_req = 1; addr_ok = 1;
        tick();
        tick();
        #4;
        chk("full_req0", req, 0);
        step();
        data_ok = 1;
        #4;
        chk("full_pop_req0", req, 0);
        step();
        data_ok = 0;
        #4;
        chk("full_reopen", req, 1);
        step();
        // back-to-back push/pop at count 1 across pointer wrap
        for (int i = 0; i < 10; i++) begin
            data_ok = 1; addr_ok = 1;
            inst_req = i[0]; data_req = ~i[0];
            tick();
        end
        idle_inputs();
        data_ok = 1;
        tick();
        tick();
        // spurious response
        #4;
        chk("spur_inst", inst_data_ok, 0);
        chk("spur_data", data_data_ok, 0);
        step();
        data_ok = 0;
        #4;
        chk("spur_sticky", err_spurious, 1);
        step();
        // reset mid-hold
        inst_req = 1;
        tick();
        reset = 0;
        #1;
        chk("rst_hold_req", req, 0);
        #3;
        step();
        reset = 1; data_req = 1; addr_ok = 1;
        #4;
        chk("rst_idle_grant", data_addr_ok, 1);
        chk("rst_err_clr", err_spurious, 0);
        step();
        idle_inputs();
        data_ok = 1;
        tick();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            reset      = $urandom_range(0, 63) != 0;
            inst_req   = $urandom_range(0, 3) != 0;
            data_req   = $urandom_range(0, 1);
            data_wr    = $urandom_range(0, 1);
            data_size  = 2'($urandom_range(0, 2));
            data_wstrb = 4'($urandom);
            inst_addr  = $urandom;
            data_addr  = $urandom;
            data_wdata = $urandom;
            addr_ok    = $urandom_range(0, 1);
            data_ok    = $urandom_range(0, 2) == 0;
            rdata      = $urandom;
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
